// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock-setting controller: FSM states,
// field indices into the strobe vectors, BCD field maxima and wrap-down burst lengths.
package clock_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_SET_HR  = 3'd1,
      ST_SET_MIN = 3'd2,
      ST_SET_SEC = 3'd3,
      ST_WRAP_DN = 3'd4
   } state_e;

   localparam logic [1:0] FLD_SEC = 2'd0;
   localparam logic [1:0] FLD_MIN = 2'd1;
   localparam logic [1:0] FLD_HR  = 2'd2;

   localparam logic [7:0] MAX_SEC = 8'h59;
   localparam logic [7:0] MAX_MIN = 8'h59;
   localparam logic [7:0] MAX_HR  = 8'h23;

   localparam int BURST_W = 7;
   localparam logic [BURST_W-1:0] BURST_SEC_MIN = 7'd41;
   localparam logic [BURST_W-1:0] BURST_HR      = 7'd77;

   // o_field encoding doubles as the low bits of the matching state
   function automatic state_e mode_state(input logic [1:0] field);
      case (field)
         2'd0:    return ST_RUN;
         2'd1:    return ST_SET_HR;
         2'd2:    return ST_SET_MIN;
         default: return ST_SET_SEC;
      endcase
   endfunction

endpackage

// File: rtl/btn_press_gen.sv
// Per-button press generator: rising-edge detect on a debounced level, plus
// optional hold-to-repeat when built with AUTO_REPEAT_EN and REPEAT_EN is set.
module btn_press_gen #(
   parameter int REPEAT_DLY = 500,
   parameter int REPEAT_PER = 100,
   parameter bit REPEAT_EN  = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   input  logic i_arm,
   output logic o_press
);

   logic btn_q;
   logic rpt;

   always_ff @(posedge i_clk) begin
      if (i_rst) btn_q <= 1'b0;
      else       btn_q <= i_btn;
   end

`ifdef AUTO_REPEAT_EN
   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CW      = $clog2(CNT_MAX + 1);

   generate
      if (REPEAT_EN) begin : g_rpt
         logic [CW-1:0] rpt_cnt;

         // down-counter reloads while released or disarmed, so each hold starts fresh
         always_ff @(posedge i_clk) begin
            if (i_rst)                         rpt_cnt <= '0;
            else if (!btn_q || !i_btn || !i_arm) rpt_cnt <= CW'(REPEAT_DLY - 1);
            else if (rpt_cnt == '0)            rpt_cnt <= CW'(REPEAT_PER - 1);
            else                               rpt_cnt <= rpt_cnt - 1'b1;
         end

         assign rpt = i_btn & btn_q & i_arm & (rpt_cnt == '0);
      end else begin : g_edge_only
         logic unused_cfg;
         assign unused_cfg = i_arm ^ (REPEAT_DLY > REPEAT_PER);
         assign rpt = 1'b0;
      end
   endgenerate
`else
   logic unused_cfg;
   assign unused_cfg = i_arm ^ REPEAT_EN ^ (REPEAT_DLY > REPEAT_PER);
   assign rpt = 1'b0;
`endif

   assign o_press = (i_btn & ~btn_q) | rpt;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock time-setting controller: 1 Hz run-mode advance, per-field set/clear/down
// with a wrap-down burst, blink control. Up/down auto-repeat under AUTO_REPEAT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_RUN     | time advances on i_tick; edit buttons ignored
// ST_SET_HR  | hours selected for editing; time frozen
// ST_SET_MIN | minutes selected for editing; time frozen
// ST_SET_SEC | seconds selected for editing; time frozen
// ST_WRAP_DN | o_down burst walking the selected field from 00 to its maximum
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int REPEAT_DLY = 500,
   parameter int REPEAT_PER = 100
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic       i_btn_mode,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_clear,
   input  logic [7:0] i_sec,
   input  logic [7:0] i_min,
   input  logic [7:0] i_hr,
   output logic [2:0] o_up,
   output logic [2:0] o_down,
   output logic [2:0] o_clear,
   output logic [1:0] o_field,
   output logic       o_busy,
   output logic       o_blink
);

   state_e             state, state_n;
   logic [BURST_W-1:0] burst_cnt, burst_n;
   logic [2:0]         up_n, down_n, clr_n;
   logic [1:0]         field_n, sel;
   logic               busy_n, blink_n, arm;
   logic [7:0]         sel_val, sel_max;
   logic               p_mode, p_up, p_dn, p_clr;

   assign arm = (state == ST_SET_HR) || (state == ST_SET_MIN) || (state == ST_SET_SEC);

   btn_press_gen #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b0)) u_mode (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_mode), .i_arm(arm), .o_press(p_mode));
   btn_press_gen #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1)) u_up (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_up), .i_arm(arm), .o_press(p_up));
   btn_press_gen #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b1)) u_down (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_down), .i_arm(arm), .o_press(p_dn));
   btn_press_gen #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .REPEAT_EN(1'b0)) u_clear (
      .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_clear), .i_arm(arm), .o_press(p_clr));

   // o_field 1/2/3 (hr/min/sec) maps onto strobe index 2/1/0
   assign sel = 2'd3 - o_field;

   always_comb begin
      sel_val = i_sec;
      sel_max = MAX_SEC;
      case (o_field)
         2'd1:    begin sel_val = i_hr;  sel_max = MAX_HR;  end
         2'd2:    begin sel_val = i_min; sel_max = MAX_MIN; end
         default: begin sel_val = i_sec; sel_max = MAX_SEC; end
      endcase
   end

   always_comb begin
      state_n = state;
      burst_n = burst_cnt;
      up_n    = '0;
      down_n  = '0;
      clr_n   = '0;
      field_n = o_field;
      busy_n  = 1'b0;
      blink_n = o_blink;
      case (state)
         ST_RUN: begin
            blink_n = 1'b1;
            if (i_tick) begin
               if (i_sec == MAX_SEC) begin
                  clr_n[FLD_SEC] = 1'b1;
                  if (i_min == MAX_MIN) begin
                     clr_n[FLD_MIN] = 1'b1;
                     if (i_hr == MAX_HR) clr_n[FLD_HR] = 1'b1;
                     else                up_n[FLD_HR]  = 1'b1;
                  end else begin
                     up_n[FLD_MIN] = 1'b1;
                  end
               end else begin
                  up_n[FLD_SEC] = 1'b1;
               end
            end
            if (p_mode) begin
               field_n = o_field + 2'd1;
               state_n = mode_state(field_n);
            end
         end
         ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
            if (i_tick) blink_n = ~o_blink;
            if (p_mode) begin
               field_n = o_field + 2'd1;
               state_n = mode_state(field_n);
               blink_n = 1'b1;
            end else if (p_clr) begin
               clr_n[sel] = 1'b1;
            end else if (p_up ^ p_dn) begin
               if (p_up) begin
                  if (sel_val == sel_max) clr_n[sel] = 1'b1;
                  else                    up_n[sel]  = 1'b1;
               end else if (sel_val == 8'h00) begin
                  state_n     = ST_WRAP_DN;
                  busy_n      = 1'b1;
                  down_n[sel] = 1'b1;
                  burst_n     = (sel == FLD_HR) ? (BURST_HR - 7'd1) : (BURST_SEC_MIN - 7'd1);
               end else begin
                  down_n[sel] = 1'b1;
               end
            end
         end
         ST_WRAP_DN: begin
            if (burst_cnt == '0) begin
               state_n = mode_state(o_field);
               blink_n = 1'b1;
            end else begin
               busy_n      = 1'b1;
               down_n[sel] = 1'b1;
               burst_n     = burst_cnt - 7'd1;
            end
         end
         default: begin
            state_n = ST_RUN;
            field_n = 2'd0;
            blink_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= ST_RUN;
         burst_cnt <= '0;
         o_up      <= '0;
         o_down    <= '0;
         o_clear   <= '0;
         o_field   <= 2'd0;
         o_busy    <= 1'b0;
         o_blink   <= 1'b1;
      end else begin
         state     <= state_n;
         burst_cnt <= burst_n;
         o_up      <= up_n;
         o_down    <= down_n;
         o_clear   <= clr_n;
         o_field   <= field_n;
         o_busy    <= busy_n;
         o_blink   <= blink_n;
      end
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DLY, default 500, the cycles a held button must stay high before the first auto-repeat.
REQ-002 SHALL have parameter REPEAT_PER, default 100, the cycles between successive auto-repeats.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port i_tick, input, 1, a one-cycle 1 Hz strobe.
REQ-006 SHALL have ports i_btn_mode, i_btn_up, i_btn_down and i_btn_clear, each input, 1, a debounced button level.
REQ-007 SHALL have ports i_sec, i_min and i_hr, each input, 8, the current field value as {tens, ones} BCD from the 00-99 counters.
REQ-008 SHALL have ports o_up, o_down and o_clear, each output, 3, one-cycle counter strobes indexed [0]=sec, [1]=min, [2]=hr.
REQ-009 SHALL have port o_field, output, 2, the current mode: 0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC.
REQ-010 SHALL have port o_busy, output, 1, high while a wrap-down burst is in progress.
REQ-011 SHALL have port o_blink, output, 1, the display blink enable for the selected field.

Function
REQ-012 SHALL register every output; a strobe is asserted the cycle after its triggering event.
REQ-013 SHALL define a press as a rising edge of a button level, detected against that button's value on the previous cycle.
REQ-014 SHALL implement states RUN, SET_HR, SET_MIN, SET_SEC and WRAP_DN.
REQ-015 SHALL advance the mode on a mode press in the order RUN->SET_HR->SET_MIN->SET_SEC->RUN.
REQ-016 SHALL act on i_tick in RUN only; in RUN, tick -> o_up[0], except when i_sec==59, which gives o_clear[0] plus the minute action.
REQ-017 SHALL define the minute action as o_up[1], except when i_min==59, which gives o_clear[1] plus the hour action.
REQ-018 SHALL define the hour action as o_up[2], except when i_hr==23, which gives o_clear[2].
REQ-019 SHALL ignore i_tick in the SET and WRAP_DN states, so time is frozen during setting.
REQ-020 SHALL, on an up press in a SET state, strobe o_up for the selected field, or o_clear if that field is at its maximum (sec/min 59, hr 23).
REQ-021 SHALL, on a clear press in a SET state, strobe o_clear for the selected field.
REQ-022 SHALL, on a down press in a SET state with the selected field not 00, strobe o_down for that field.
REQ-023 SHALL, on a down press in a SET state with the selected field at 00, enter WRAP_DN.
REQ-024 SHALL, in WRAP_DN, hold o_down high for consecutive cycles: 41 for sec/min (00->59) or 77 for hr (00->23).
REQ-025 SHALL return from WRAP_DN to the originating SET state on the cycle after the last down strobe.
REQ-026 SHALL hold o_busy high for exactly the WRAP_DN cycles.
REQ-027 SHALL drop all presses and repeats during WRAP_DN; none are queued.
REQ-028 SHALL resolve simultaneous presses so that a mode press beats up/down/clear and the others are dropped.
REQ-029 SHALL drop both presses when up and down are pressed in the same cycle.
REQ-030 SHALL let clear beat up/down when pressed in the same cycle.
REQ-031 SHALL ignore up, down and clear presses in RUN.
REQ-032 SHALL hold o_blink at 1 in RUN, set it to 1 on entry to any SET state, and toggle it on each i_tick while in SET states.
REQ-033 SHALL never assert more than one of o_up/o_down/o_clear for the same field in the same cycle.

Reset
REQ-034 SHALL, on i_rst, set the state to RUN, o_field=0, o_up/o_down/o_clear=0, o_busy=0, o_blink=1, and the burst and repeat counters to 0.
REQ-035 SHALL clear the button-history registers to 0 on reset, so a button held through reset yields one press on the first cycle after release.
REQ-036 SHALL, when reset is asserted during WRAP_DN, abort the burst immediately and leave the counter at its partial value.

Configuration
REQ-037 SHALL, with AUTO_REPEAT_EN defined, generate a repeat press after up/down has been held REPEAT_DLY cycles in a SET state, then every REPEAT_PER cycles while held.
REQ-038 SHALL restart the repeat timer on release and on exit from WRAP_DN.
REQ-039 SHALL, without AUTO_REPEAT_EN, act on edges only, with no repeat logic and the parameters unused.

Structure
REQ-040 SHALL place the state enum, the field index constants (SEC=0, MIN=1, HR=2), the maxima (59, 59, 23) and the burst lengths (41, 77) in package clock_ctrl_pkg.
REQ-041 SHALL implement edge detect plus auto-repeat in sub-module btn_press_gen, one instance per button, with repeat enabled for up/down only.

Verification
REQ-042 SHALL cover: RUN with sec=59, min=59, hr=23, then i_tick -> next cycle o_clear=3'b111, o_up=0.
REQ-043 SHALL cover: SET_MIN with min=00, then down press -> o_busy=1 and o_down[1] high 41 cycles -> min=59, back in SET_MIN.
REQ-044 SHALL cover: SET_HR with hr=23, then up press -> o_clear[2] for one cycle, hr=00.
REQ-045 SHALL cover: up press during WRAP_DN -> ignored, burst length unchanged; mode and up pressed together -> only the mode advances.
REQ-046 SHALL cover, with AUTO_REPEAT_EN: up held 800 cycles in SET_SEC -> strobes at press+1, REPEAT_DLY+1 and each REPEAT_PER thereafter (4 total).
REQ-047 SHALL cover: i_rst asserted mid-burst at hr=80 -> next cycle all strobes 0, o_field=0, hr remains 80.
